// File: rtl/ifft_frame_loader_if.sv
// Sample stream, memory write port and IFFT core handshake for the frame loader.
interface ifft_frame_loader_if #(
  parameter int unsigned N_LOG2 = 5,
  parameter int unsigned DW     = 28
);
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              in_last;
  logic [N_LOG2-1:0] waddr;
  logic [DW-1:0]     wdata;
  logic              write;
  logic              fft_start;
  logic              fft_done;
  logic              frame_err;
  logic [7:0]        frame_cnt;

  // Upstream source / core side.
  modport master (
    output in_valid, in_data, in_last, fft_done,
    input  in_ready, waddr, wdata, write, fft_start, frame_err, frame_cnt
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data, in_last, fft_done,
    output in_ready, waddr, wdata, write, fft_start, frame_err, frame_cnt
  );
endinterface

// File: rtl/ifft_frame_loader.sv
// Loads 32 complex samples into the IFFT working memory (bit-reversed,
// optionally conjugated), then starts the core and waits for it to finish.
module ifft_frame_loader #(
  parameter int unsigned N_LOG2 = 5,
  parameter int unsigned DW     = 28,
  parameter int unsigned BITREV = 1,
  parameter int unsigned CONJ   = 1
) (
  input  logic clk,
  input  logic rst_n,
  ifft_frame_loader_if.slave bus
);
  localparam int unsigned HW    = DW / 2;
  localparam int unsigned CNT_W = 8;
  localparam logic [N_LOG2-1:0] IDX_LAST = {N_LOG2{1'b1}};
  localparam logic [HW-1:0]     IM_MIN   = {1'b1, {(HW-1){1'b0}}};
  localparam logic [HW-1:0]     IM_MAX   = {1'b0, {(HW-1){1'b1}}};

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [N_LOG2-1:0] idx_q, idx_d;
  logic              write_q, write_d;
  logic [N_LOG2-1:0] waddr_q, waddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept_c;
  logic [N_LOG2-1:0] addr_c;
  logic [HW-1:0]     im_c;
  logic [DW-1:0]     proc_c;

  assign bus.in_ready  = (state_q == S_LOAD);
  assign accept_c      = bus.in_valid && (state_q == S_LOAD);
  assign bus.write     = write_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.fft_start = start_q;
  assign bus.frame_err = err_q;
  assign bus.frame_cnt = cnt_q;

  // Write address: bit-reversed sample index so the core sees natural-order output.
  always_comb begin
    addr_c = idx_q;
    if (BITREV != 0) begin
      for (int i = 0; i < int'(N_LOG2); i++) begin
        addr_c[i] = idx_q[int'(N_LOG2) - 1 - i];
      end
    end
  end

  // Sample conditioning: saturating negation of imag so the forward kernel yields an IFFT.
  always_comb begin
    im_c = bus.in_data[HW-1:0];
    if (CONJ != 0) begin
      if (bus.in_data[HW-1:0] == IM_MIN) begin
        im_c = IM_MAX;
      end else begin
        im_c = ~bus.in_data[HW-1:0] + HW'(1);
      end
    end
    proc_c = {bus.in_data[DW-1:HW], im_c};
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    write_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    start_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOAD: begin
        if (accept_c) begin
          write_d = 1'b1;
          waddr_d = addr_c;
          wdata_d = proc_c;
          if (idx_q == IDX_LAST) begin
            // Full frame: a missing in_last is flagged but the frame still runs.
            state_d = S_START;
            idx_d   = '0;
            if (!bus.in_last) err_d = 1'b1;
          end else if (bus.in_last) begin
            // Early in_last: drop the partial frame and restart at address 0.
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + N_LOG2'(1);
          end
        end
      end
      S_START: begin
        start_d = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (bus.fft_done) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_LOAD;
        idx_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
      write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ifft_frame_loader.sv
// Directed per-cycle vector bench for ifft_frame_loader.
module tb_ifft_frame_loader;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ifft_frame_loader_if #(.N_LOG2(5), .DW(28)) bus ();

  ifft_frame_loader #(
    .N_LOG2(5), .DW(28), .BITREV(1), .CONJ(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string       tag;
    logic        rst_n;
    logic        valid;
    logic [27:0] data;
    logic        last;
    logic        done;
    logic        e_write;
    logic [4:0]  e_waddr;
    logic [27:0] e_wdata;
    logic        e_start;
    logic        e_ready;
    logic        e_err;
    logic [7:0]  e_cnt;
    logic        chk_all;
  } vec_t;

  vec_t vq[$];
  int   cnt_e;
  int   err_e;
  int   applied;
  int   miscompares;

  function automatic logic [4:0] brev(input int i);
    logic [4:0] b;
    b = 5'(i);
    return {b[0], b[1], b[2], b[3], b[4]};
  endfunction

  // Expected memory word: real untouched, imag negated with +8191 ceiling.
  function automatic logic [27:0] exp_proc(input logic [27:0] d);
    logic signed [13:0] s;
    int neg;
    s   = d[13:0];
    neg = -int'(s);
    if (neg > 8191) neg = 8191;
    return {d[27:14], 14'(neg)};
  endfunction

  task automatic push(input string tag, input logic r, input logic v, input logic [27:0] d,
                      input logic l, input logic dn, input logic ew, input logic [4:0] ea,
                      input logic [27:0] ed, input logic es, input logic er, input logic ca);
    vec_t x;
    x.tag = tag; x.rst_n = r; x.valid = v; x.data = d; x.last = l; x.done = dn;
    x.e_write = ew; x.e_waddr = ea; x.e_wdata = ed; x.e_start = es; x.e_ready = er;
    x.e_err = (err_e != 0); x.e_cnt = 8'(cnt_e); x.chk_all = ca;
    vq.push_back(x);
  endtask

  task automatic sample(input string tag, input int idx, input logic [27:0] d, input logic l);
    if ((l && idx < 31) || (!l && idx == 31)) err_e = 1;
    push(tag, 1'b1, 1'b1, d, l, 1'b0, 1'b1, brev(idx), exp_proc(d), 1'b0, (idx != 31), 1'b0);
  endtask

  task automatic idle(input string tag);
    push(tag, 1'b1, 1'b0, 28'h5A5A5A5, 1'b1, 1'b1, 1'b0, 5'd0, 28'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic start_cyc(input string tag, input logic dn);
    cnt_e++;
    push(tag, 1'b1, 1'b1, 28'h1234567, 1'b0, dn, 1'b0, 5'd0, 28'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic busy(input string tag, input int n, input logic dn);
    for (int k = 0; k < n; k++)
      push(tag, 1'b1, 1'b1, 28'h7654321, 1'b0, dn, 1'b0, 5'd0, 28'd0, 1'b0, dn, 1'b0);
  endtask

  task automatic rst_cyc(input string tag);
    cnt_e = 0;
    err_e = 0;
    push(tag, 1'b0, 1'b1, 28'hABCDEF1, 1'b1, 1'b1, 1'b0, 5'd0, 28'd0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.fft_done = 1'b0;
    cnt_e = 0; err_e = 0; applied = 0; miscompares = 0;

    // Reset state.
    rst_cyc("reset");
    // Ramp frame, then long BUSY with valid held high, then a 1-cycle done.
    for (int i = 0; i < 32; i++) sample("ramp", i, {14'(i), 14'(i)}, i == 31);
    start_cyc("ramp_start", 1'b0);
    busy("busy_hold", 50, 1'b0);
    busy("busy_done", 1, 1'b1);
    // Saturation corners (literal expectations), then in_last on the 10th sample.
    push("sat_im_min", 1'b1, 1'b1, 28'h8002000, 1'b0, 1'b0, 1'b1, 5'd0, 28'h8001FFF, 1'b0, 1'b1, 1'b0);
    push("sat_im_zero", 1'b1, 1'b1, 28'h0014000, 1'b0, 1'b0, 1'b1, 5'd16, 28'h0014000, 1'b0, 1'b1, 1'b0);
    for (int i = 2; i < 10; i++) sample("early_last", i, {14'(i * 300), 14'(i * 1111)}, i == 9);
    idle("no_start_a");
    idle("no_start_b");
    // Full frame at half rate after the dropped partial frame; done seen while idle in LOAD.
    for (int i = 0; i < 32; i++) begin
      idle("toggle_gap");
      sample("toggle", i, {14'(i * 77 + 3), 14'(8000 - i * 517)}, i == 31);
    end
    start_cyc("toggle_start", 1'b1);
    busy("busy_min", 1, 1'b1);
    // Reset mid-frame, then a frame missing in_last, then reset during BUSY.
    for (int i = 0; i < 20; i++) sample("pre_rst", i, {14'(i + 9), 14'(i * 3)}, 1'b0);
    rst_cyc("rst_mid");
    for (int i = 0; i < 32; i++) sample("no_last", i, {14'(100 - i), 14'(i * 250 - 4000)}, 1'b0);
    start_cyc("no_last_start", 1'b0);
    busy("busy_pre_rst", 3, 1'b0);
    rst_cyc("rst_busy");
    for (int i = 0; i < 3; i++) sample("post_rst", i, {14'(i + 1), 14'(8191 - i)}, 1'b0);
    idle("post_idle");

    foreach (vq[i]) begin
      logic ok;
      @(negedge clk);
      rst_n        = vq[i].rst_n;
      bus.in_valid = vq[i].valid;
      bus.in_data  = vq[i].data;
      bus.in_last  = vq[i].last;
      bus.fft_done = vq[i].done;
      @(posedge clk);
      #1;
      applied++;
      ok = (bus.write === vq[i].e_write) && (bus.fft_start === vq[i].e_start) &&
           (bus.in_ready === vq[i].e_ready) && (bus.frame_err === vq[i].e_err) &&
           (bus.frame_cnt === vq[i].e_cnt);
      if (vq[i].e_write || vq[i].chk_all)
        ok = ok && (bus.waddr === vq[i].e_waddr) && (bus.wdata === vq[i].e_wdata);
      if (!ok) begin
        miscompares++;
        $display("FAIL vec %0d %s: got write=%0b waddr=%0d wdata=%h start=%0b ready=%0b err=%0b cnt=%0d, expected write=%0b waddr=%0d wdata=%h start=%0b ready=%0b err=%0b cnt=%0d",
                 i, vq[i].tag, bus.write, bus.waddr, bus.wdata, bus.fft_start, bus.in_ready,
                 bus.frame_err, bus.frame_cnt, vq[i].e_write, vq[i].e_waddr, vq[i].e_wdata,
                 vq[i].e_start, vq[i].e_ready, vq[i].e_err, vq[i].e_cnt);
      end
      if (vq[i].chk_all &&
          !((bus.write === 1'b0) && (bus.waddr === 5'd0) && (bus.wdata === 28'd0) &&
            (bus.fft_start === 1'b0) && (bus.frame_err === 1'b0) &&
            (bus.frame_cnt === 8'd0) && (bus.in_ready === 1'b1))) begin
        miscompares++;
        $display("FAIL reset state vec %0d %s: write=%0b waddr=%0d wdata=%h start=%0b err=%0b cnt=%0d ready=%0b",
                 i, vq[i].tag, bus.write, bus.waddr, bus.wdata, bus.fft_start,
                 bus.frame_err, bus.frame_cnt, bus.in_ready);
      end
      if ((vq[i].tag == "busy_hold") &&
          ((bus.write !== 1'b0) || (bus.in_ready !== 1'b0))) begin
        miscompares++;
        $display("FAIL expired wait vec %0d: write=%0b ready=%0b while fft_done low",
                 i, bus.write, bus.in_ready);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
